pwm_capture: RTL



---
 rtl/pwm_capture.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: multi-channel RC/servo PWM high-time measurement front end.
// Each channel synchronizes its pin, times the high phase in 1 us ticks from
// a shared prescaler, and publishes the latest in-range width with valid,
// update and error flags.
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample majority
// filter per channel, which costs one extra cycle of pin-to-update latency.

module pwm_capture_ch #(
    parameter int W          = 16,
    parameter int MIN_US     = 800,
    parameter int MAX_US     = 2200,
    parameter int TIMEOUT_US = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pin,
    input  logic         tick,
    input  logic         primed,
    output logic [W-1:0] width,
    output logic         valid,
    output logic         update,
    output logic         err
);

    localparam logic [W-1:0] MIN_W = W'(MIN_US);
    localparam logic [W-1:0] MAX_W = W'(MAX_US);
    localparam logic [W-1:0] TO_W  = W'(TIMEOUT_US);

    typedef enum logic [1:0] {WAIT_LOW, ARMED, HIGH, OVERRUN} state_t;

    logic s1, s2, s3;
    logic lvl, rise, fall;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic s4, filt, filt_d;

    // two-flop synchronizer, two history samples, registered majority vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            s4     <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            s1     <= pin;
            s2     <= s1;
            s3     <= s2;
            s4     <= s3;
            filt   <= (s2 & s3) | (s2 & s4) | (s3 & s4);
            filt_d <= filt;
        end
    end

    // a lone high or low sample never wins the vote, so spikes make no edge
    assign lvl  = filt;
    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;
`else
    logic lvl_q, rise_q, fall_q;

    // two-flop synchronizer plus registered edge detect on s2/s3; level and
    // edges are captured on the same edge so the FSM sees them aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1     <= pin;
            s2     <= s1;
            s3     <= s2;
            lvl_q  <= s2;
            rise_q <= s2 & ~s3;
            fall_q <= ~s2 & s3;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;
    assign fall = fall_q;
`endif

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] tocnt;
    logic         upd_nxt, err_nxt;

    // state and width counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // next state, counting and capture decisions
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        upd_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            // primed keeps the reset-cleared sync chain from looking like a
            // low pin while a pulse is already in progress
            WAIT_LOW: if (primed && !lvl) state_nxt = ARMED;
            ARMED: begin
                if (rise) begin
                    cnt_nxt   = '0;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                // fall implies lvl low, so a coincident tick is never counted
                if (fall) begin
                    state_nxt = ARMED;
                    if (cnt >= MIN_W) upd_nxt = 1'b1;
                    else              err_nxt = 1'b1;
                end else if (tick && lvl) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == MAX_W) begin
                        err_nxt   = 1'b1;
                        state_nxt = OVERRUN;
                    end
                end
            end
            OVERRUN: if (!lvl) state_nxt = ARMED;
            default: state_nxt = WAIT_LOW;
        endcase
    end

    // published width/valid, event pulses and loss-of-signal timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width  <= '0;
            valid  <= 1'b0;
            update <= 1'b0;
            err    <= 1'b0;
            tocnt  <= '0;
        end else begin
            update <= upd_nxt;
            err    <= err_nxt;
            if (upd_nxt)                   tocnt <= '0;
            else if (tick && tocnt != TO_W) tocnt <= tocnt + 1'b1;
            if (upd_nxt) begin
                width <= cnt;
                valid <= 1'b1;
            end else if (tocnt == TO_W) begin
                width <= '0;
                valid <= 1'b0;
            end
        end
    end

endmodule

module pwm_capture #(
    parameter int NUM_CH     = 6,
    parameter int CLK_DIV    = 48,
    parameter int W          = 16,
    parameter int MIN_US     = 800,
    parameter int MAX_US     = 2200,
    parameter int TIMEOUT_US = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_CH-1:0]     i_pwm,
    output logic [NUM_CH*W-1:0]   o_width,
    output logic [NUM_CH-1:0]     o_valid,
    output logic [NUM_CH-1:0]     o_update,
    output logic [NUM_CH-1:0]     o_err
);

    localparam int PW     = $clog2(CLK_DIV);
    // cycles until every sync/filter stage holds a real pin sample
    localparam int STAGES = 5;

    logic [PW-1:0]   pre;
    logic            tick;
    logic [STAGES:0] vld_pipe;

    assign tick = (pre == PW'(CLK_DIV - 1));

    // free-running 1 us prescaler shared by all channels
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pre <= '0;
        else          pre <= tick ? '0 : pre + 1'b1;
    end

    // ones shift in after reset; the top bit marks the pipeline as primed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        pwm_capture_ch #(
            .W          (W),
            .MIN_US     (MIN_US),
            .MAX_US     (MAX_US),
            .TIMEOUT_US (TIMEOUT_US)
        ) u_ch (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .pin    (i_pwm[n]),
            .tick   (tick),
            .primed (vld_pipe[STAGES]),
            .width  (o_width[n*W +: W]),
            .valid  (o_valid[n]),
            .update (o_update[n]),
            .err    (o_err[n])
        );
    end

endmodule
